// File: rtl/decode_disp_imm_extract.sv
// Decode stage that slices ModRM/SIB/displacement/immediate from the post-opcode window behind a 2-entry skid buffer.
// Optional DECODE_EXTRACT_STATS_EN adds saturating accept/stall counters.
module decode_disp_imm_extract #(
    parameter int unsigned WINDOW_BYTES = 12,
    parameter int unsigned MAX_LEN      = 15
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [8*WINDOW_BYTES-1:0] in_bytes,
    input  logic [1:0]                addressing_bytes,
    input  logic [3:0]                displacement_bytes,
    input  logic [2:0]                immediate_bytes,
    input  logic                      imm_sext,
    input  logic [3:0]                pre_op_len,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [7:0]                modrm,
    output logic [7:0]                sib,
    output logic [31:0]               displacement,
    output logic [31:0]               immediate,
    output logic [4:0]                instr_length,
    output logic                      length_error
`ifdef DECODE_EXTRACT_STATS_EN
    ,
    output logic [15:0]               accept_count,
    output logic [15:0]               stall_count
`endif
);

    localparam int unsigned LEN_W = 5;

    typedef struct packed {
        logic [7:0]       modrm;
        logic [7:0]       sib;
        logic [31:0]      disp;
        logic [31:0]      imm;
        logic [LEN_W-1:0] len;
        logic             err;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Extend a little-endian field of 0/1/2/4 bytes to 32 bits.
    function automatic logic [31:0] extend_field(input logic [31:0] raw, input logic [2:0] size,
                                                 input logic sext);
        logic [31:0] res;
        case (size)
            3'd1:    res = sext ? {{24{raw[7]}}, raw[7:0]} : {24'd0, raw[7:0]};
            3'd2:    res = sext ? {{16{raw[15]}}, raw[15:0]} : {16'd0, raw[15:0]};
            3'd4:    res = raw;
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    logic [1:0]       w_addr_eff;
    logic [2:0]       w_disp_eff;
    logic [2:0]       w_imm_eff;
    logic [2:0]       w_imm_off;
    logic             w_code_err;
    logic [31:0]      w_disp_raw;
    logic [31:0]      w_imm_raw;
    logic [LEN_W-1:0] w_len;
    entry_t           w_entry;

    // Field extraction on the input side; illegal size codes collapse to a legal size.
    always_comb begin
        w_code_err = 1'b0;
        w_addr_eff = addressing_bytes;
        if (addressing_bytes == 2'd3) begin
            w_addr_eff = 2'd2;
            w_code_err = 1'b1;
        end
        case (displacement_bytes)
            4'd0, 4'd1, 4'd2, 4'd4: w_disp_eff = 3'(displacement_bytes);
            default: begin
                w_disp_eff = 3'd0;
                w_code_err = 1'b1;
            end
        endcase
        case (immediate_bytes)
            3'd0, 3'd1, 3'd2, 3'd4: w_imm_eff = immediate_bytes;
            default: begin
                w_imm_eff  = 3'd0;
                w_code_err = 1'b1;
            end
        endcase
        w_imm_off  = 3'(w_addr_eff) + w_disp_eff;
        w_disp_raw = in_bytes[32'(w_addr_eff) * 8 +: 32];
        w_imm_raw  = in_bytes[32'(w_imm_off) * 8 +: 32];
        w_len      = LEN_W'(pre_op_len) + LEN_W'(w_addr_eff) + LEN_W'(w_disp_eff) + LEN_W'(w_imm_eff);

        w_entry.modrm = (w_addr_eff != 2'd0) ? in_bytes[7:0] : 8'd0;
        w_entry.sib   = (w_addr_eff == 2'd2) ? in_bytes[15:8] : 8'd0;
        w_entry.disp  = extend_field(w_disp_raw, w_disp_eff, 1'b1);
        w_entry.imm   = extend_field(w_imm_raw, w_imm_eff, imm_sext);
        w_entry.len   = w_len;
        w_entry.err   = w_code_err | (w_len > LEN_W'(MAX_LEN));
    end

    state_t r_state;
    state_t w_state_nxt;
    logic   r_in_ready;
    logic   r_out_valid;
    entry_t r_m;
    entry_t r_s;
    logic   w_xfer_in;
    logic   w_load_m_in;
    logic   w_load_m_skid;
    logic   w_load_s;

    assign w_xfer_in = in_valid & r_in_ready;

    // Skid-buffer next state; flush wins over any simultaneous transfer.
    always_comb begin
        w_state_nxt   = r_state;
        w_load_m_in   = 1'b0;
        w_load_m_skid = 1'b0;
        w_load_s      = 1'b0;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_xfer_in) begin
                        w_load_m_in = 1'b1;
                        w_state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (w_xfer_in && out_ready) begin
                        w_load_m_in = 1'b1;
                    end else if (w_xfer_in) begin
                        w_load_s    = 1'b1;
                        w_state_nxt = FULL;
                    end else if (out_ready) begin
                        w_state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        w_load_m_skid = 1'b1;
                        w_state_nxt   = ONE;
                    end
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != FULL);
            r_out_valid <= (w_state_nxt != EMPTY);
        end
    end

    // Payload registers only move on loads, so a flush leaves the last data visible.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_m <= '0;
            r_s <= '0;
        end else begin
            if (w_load_m_in) begin
                r_m <= w_entry;
            end else if (w_load_m_skid) begin
                r_m <= r_s;
            end
            if (w_load_s) begin
                r_s <= w_entry;
            end
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign modrm        = r_m.modrm;
    assign sib          = r_m.sib;
    assign displacement = r_m.disp;
    assign immediate    = r_m.imm;
    assign instr_length = r_m.len;
    assign length_error = r_m.err;

`ifdef DECODE_EXTRACT_STATS_EN
    logic [15:0] r_accept_count;
    logic [15:0] r_stall_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_accept_count <= 16'd0;
            r_stall_count  <= 16'd0;
        end else begin
            if (w_xfer_in && (r_accept_count != 16'hFFFF)) begin
                r_accept_count <= r_accept_count + 16'd1;
            end
            if (r_out_valid && !out_ready && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign accept_count = r_accept_count;
    assign stall_count  = r_stall_count;
`endif

endmodule

// File: tb/tb_decode_disp_imm_extract.sv
// Directed self-checking bench for decode_disp_imm_extract (stats checks when DECODE_EXTRACT_STATS_EN is defined).
module tb_decode_disp_imm_extract;

    localparam int unsigned WB = 12;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [8*WB-1:0] in_bytes;
    logic [1:0]    addressing_bytes;
    logic [3:0]    displacement_bytes;
    logic [2:0]    immediate_bytes;
    logic          imm_sext;
    logic [3:0]    pre_op_len;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    modrm;
    logic [7:0]    sib;
    logic [31:0]   displacement;
    logic [31:0]   immediate;
    logic [4:0]    instr_length;
    logic          length_error;
`ifdef DECODE_EXTRACT_STATS_EN
    logic [15:0]   accept_count;
    logic [15:0]   stall_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decode_disp_imm_extract #(.WINDOW_BYTES(WB), .MAX_LEN(15)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_bytes(in_bytes),
        .addressing_bytes(addressing_bytes), .displacement_bytes(displacement_bytes),
        .immediate_bytes(immediate_bytes), .imm_sext(imm_sext), .pre_op_len(pre_op_len),
        .out_valid(out_valid), .out_ready(out_ready),
        .modrm(modrm), .sib(sib), .displacement(displacement), .immediate(immediate),
        .instr_length(instr_length), .length_error(length_error)
`ifdef DECODE_EXTRACT_STATS_EN
        , .accept_count(accept_count), .stall_count(stall_count)
`endif
    );

    task automatic drive(input logic [95:0] b, input logic [1:0] a, input logic [3:0] d,
                         input logic [2:0] i, input logic s, input logic [3:0] p);
        in_bytes = b; addressing_bytes = a; displacement_bytes = d;
        immediate_bytes = i; imm_sext = s; pre_op_len = p; in_valid = 1'b1;
    endtask

    // Drive one entry at a negedge, let it be captured, then stop driving at the following negedge.
    task automatic send_one(input logic [95:0] b, input logic [1:0] a, input logic [3:0] d,
                            input logic [2:0] i, input logic s, input logic [3:0] p);
        drive(b, a, d, i, s, p);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_bytes = '0; addressing_bytes = '0; displacement_bytes = '0;
        immediate_bytes = '0; imm_sext = 1'b0; pre_op_len = '0;
        #12;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_cmp++; if ({modrm, sib, displacement, immediate, instr_length, length_error} !== 86'd0) begin
            n_err++; $display("FAIL reset_data: got %h %h %h %h %h %b expected all zero",
                              modrm, sib, displacement, immediate, instr_length, length_error); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send_one(96'hF0_24_84, 2'd2, 4'd1, 3'd0, 1'b0, 4'd1);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
        n_cmp++; if (modrm !== 8'h84) begin n_err++; $display("FAIL basic_modrm: got %h expected 84", modrm); end
        n_cmp++; if (sib !== 8'h24) begin n_err++; $display("FAIL basic_sib: got %h expected 24", sib); end
        n_cmp++; if (displacement !== 32'hFFFFFFF0) begin n_err++; $display("FAIL basic_disp: got %h expected fffffff0", displacement); end
        n_cmp++; if (immediate !== 32'h0) begin n_err++; $display("FAIL basic_imm: got %h expected 0", immediate); end
        n_cmp++; if (instr_length !== 5'd4) begin n_err++; $display("FAIL basic_len: got %0d expected 4", instr_length); end
        n_cmp++; if (length_error !== 1'b0) begin n_err++; $display("FAIL basic_err: got %b expected 0", length_error); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain: got %b expected 0", out_valid); end
    endtask

    // Two entries on consecutive cycles differing only in imm_sext.
    task automatic test_imm_ext();
        out_ready = 1'b1;
        drive(96'h80_00_12_34_56_78_05, 2'd1, 4'd4, 3'd2, 1'b0, 4'd1);
        @(posedge clk);
        @(negedge clk);
        drive(96'h80_00_12_34_56_78_05, 2'd1, 4'd4, 3'd2, 1'b1, 4'd1);
        n_cmp++; if (displacement !== 32'h12345678) begin n_err++; $display("FAIL immz_disp: got %h expected 12345678", displacement); end
        n_cmp++; if (immediate !== 32'h00008000) begin n_err++; $display("FAIL immz_imm: got %h expected 00008000", immediate); end
        n_cmp++; if (instr_length !== 5'd8) begin n_err++; $display("FAIL immz_len: got %0d expected 8", instr_length); end
        n_cmp++; if (sib !== 8'h00) begin n_err++; $display("FAIL immz_sib: got %h expected 00", sib); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL imms_valid: got %b expected 1", out_valid); end
        n_cmp++; if (immediate !== 32'hFFFF8000) begin n_err++; $display("FAIL imms_imm: got %h expected ffff8000", immediate); end
        n_cmp++; if (displacement !== 32'h12345678) begin n_err++; $display("FAIL imms_disp: got %h expected 12345678", displacement); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(96'hE0, 2'd1, 4'd0, 3'd0, 1'b0, 4'd1);
        @(posedge clk); @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready1: got %b expected 1", in_ready); end
        n_cmp++; if (modrm !== 8'hE0) begin n_err++; $display("FAIL bp_first: got %h expected e0", modrm); end
        drive(96'hE1, 2'd1, 4'd0, 3'd0, 1'b0, 4'd1);
        @(posedge clk); @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_full: got %b expected 0", in_ready); end
        drive(96'hE2, 2'd1, 4'd0, 3'd0, 1'b0, 4'd1);
        @(posedge clk); @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold_ready: got %b expected 0", in_ready); end
        n_cmp++; if (modrm !== 8'hE0) begin n_err++; $display("FAIL bp_hold_data: got %h expected e0", modrm); end
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        n_cmp++; if (modrm !== 8'hE1) begin n_err++; $display("FAIL bp_second: got %h expected e1", modrm); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_again: got %b expected 1", in_ready); end
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if ({out_valid, modrm} !== {1'b1, 8'hE2}) begin n_err++; $display("FAIL bp_third: got %b/%h expected 1/e2", out_valid, modrm); end
        n_cmp++; if (instr_length !== 5'd2) begin n_err++; $display("FAIL bp_len: got %0d expected 2", instr_length); end
        @(posedge clk); @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b expected 0 (duplicate entry)", out_valid); end
    endtask

    task automatic test_length();
        out_ready = 1'b1;
        send_one(96'h0, 2'd1, 4'd4, 3'd4, 1'b0, 4'd14);
        n_cmp++; if (instr_length !== 5'd23) begin n_err++; $display("FAIL len_over: got %0d expected 23", instr_length); end
        n_cmp++; if (length_error !== 1'b1) begin n_err++; $display("FAIL len_over_err: got %b expected 1", length_error); end
        send_one(96'hFF_FF_FF_FF_FF_11, 2'd1, 4'd3, 3'd0, 1'b0, 4'd2);
        n_cmp++; if (displacement !== 32'h0) begin n_err++; $display("FAIL disp3_val: got %h expected 0", displacement); end
        n_cmp++; if ({instr_length, length_error} !== {5'd3, 1'b1}) begin n_err++; $display("FAIL disp3_len_err: got %0d/%b expected 3/1", instr_length, length_error); end
        send_one(96'h80_22_11, 2'd3, 4'd0, 3'd1, 1'b1, 4'd1);
        n_cmp++; if ({modrm, sib} !== 16'h1122) begin n_err++; $display("FAIL addr3_bytes: got %h%h expected 1122", modrm, sib); end
        n_cmp++; if (immediate !== 32'hFFFFFF80) begin n_err++; $display("FAIL addr3_imm: got %h expected ffffff80", immediate); end
        n_cmp++; if ({instr_length, length_error} !== {5'd4, 1'b1}) begin n_err++; $display("FAIL addr3_len_err: got %0d/%b expected 4/1", instr_length, length_error); end
        send_one(96'h00_7F_F2_34_00_00, 2'd2, 4'd2, 3'd2, 1'b1, 4'd9);
        n_cmp++; if (displacement !== 32'hFFFFF234) begin n_err++; $display("FAIL len15_disp: got %h expected fffff234", displacement); end
        n_cmp++; if (immediate !== 32'h0000007F) begin n_err++; $display("FAIL len15_imm: got %h expected 0000007f", immediate); end
        n_cmp++; if ({instr_length, length_error} !== {5'd15, 1'b0}) begin n_err++; $display("FAIL len15_len_err: got %0d/%b expected 15/0", instr_length, length_error); end
        @(negedge clk);
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(96'hA1, 2'd1, 4'd0, 3'd0, 1'b0, 4'd1);
        @(posedge clk); @(negedge clk);
        drive(96'hA2, 2'd1, 4'd0, 3'd0, 1'b0, 4'd1);
        @(posedge clk); @(negedge clk);
        flush = 1'b1;
        drive(96'hA3, 2'd1, 4'd0, 3'd0, 1'b0, 4'd1);
        @(posedge clk); @(negedge clk);
        n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL flush_full: got valid=%b ready=%b expected 0/1", out_valid, in_ready); end
        n_cmp++; if (modrm !== 8'hA1) begin n_err++; $display("FAIL flush_hold_data: got %h expected a1", modrm); end
        drive(96'hA4, 2'd1, 4'd0, 3'd0, 1'b0, 4'd1);
        @(posedge clk); @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_drop_in: got %b expected 0", out_valid); end
        n_cmp++; if (modrm !== 8'hA1) begin n_err++; $display("FAIL flush_drop_data: got %h expected a1", modrm); end
        @(posedge clk); @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_stay_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        send_one(96'hC5, 2'd1, 4'd0, 3'd0, 1'b0, 4'd1);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL areset_pre: got %b expected 1", out_valid); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL areset_now: got valid=%b ready=%b expected 0/1", out_valid, in_ready); end
        n_cmp++; if (modrm !== 8'h00) begin n_err++; $display("FAIL areset_data: got %h expected 00", modrm); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

`ifdef DECODE_EXTRACT_STATS_EN
    task automatic test_stats();
        n_cmp++; if ({accept_count, stall_count} !== 32'd0) begin n_err++; $display("FAIL stats_reset: got %0d/%0d expected 0/0", accept_count, stall_count); end
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(96'(k), 2'd1, 4'd0, 3'd0, 1'b0, 4'd1);
            @(posedge clk); @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        n_cmp++; if (accept_count !== 16'd5) begin n_err++; $display("FAIL stats_accept: got %0d expected 5", accept_count); end
        n_cmp++; if (stall_count !== 16'd3) begin n_err++; $display("FAIL stats_stall: got %0d expected 3", stall_count); end
        flush = 1'b1;
        @(posedge clk); @(negedge clk);
        flush = 1'b0;
        n_cmp++; if ({accept_count, stall_count} !== {16'd5, 16'd3}) begin n_err++; $display("FAIL stats_flush: got %0d/%0d expected 5/3", accept_count, stall_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_imm_ext();
        test_backpressure();
        test_length();
        test_flush();
        test_async_reset();
`ifdef DECODE_EXTRACT_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
